// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: bundle between the button/tick source (master) and snake_dir_ctrl (slave)
//   buttons up/down/left/right/start/sel and game_tick flow master->slave;
//   dir, step, paused, restart, count, boost flow slave->master.
interface snake_dir_ctrl_if #(parameter int CW = 2);
  logic          up, down, left, right, start, sel, game_tick;
  logic [1:0]    dir;
  logic          step, paused, restart, boost;
  logic [CW-1:0] count;
  modport master (output up, down, left, right, start, sel, game_tick,
                  input dir, step, paused, restart, count, boost);
  modport slave  (input up, down, left, right, start, sel, game_tick,
                  output dir, step, paused, restart, count, boost);
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: queues snake heading changes from button presses and applies one per game tick
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (slave)    : button levels + game_tick in; dir, step, paused, restart, count, boost out
//   optional macro SNAKE_DIR_BOOST_EN enables the registered boost output (otherwise tied 0)
module snake_dir_ctrl #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic            clock,
  input logic            reset_n,
  snake_dir_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [5:0]    btn, s1, s2, hist, press;
  logic [1:0]    q [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [1:0]    dir, cand, ref_dir;
  logic [CW-1:0] count;
  logic          step, paused, restart, tick, pop, push, rst_game;
  assign btn      = {bus.sel, bus.start, bus.right, bus.left, bus.down, bus.up};
  assign press    = s2 & ~hist;
  assign cand     = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  // new presses are judged against the last queued heading, not the live one
  assign ref_dir  = (count != '0) ? q[wp - AW'(1)] : dir;
  assign rst_game = press[5] & paused;
  assign tick     = bus.game_tick & ~paused;
  assign pop      = tick & (count != '0);
  assign push     = (|press[3:0]) & ~paused & (cand != ref_dir) &
                    (cand != (ref_dir ^ 2'd1)) & (count < CW'(DEPTH));
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      hist    <= '0;
      dir     <= 2'd3;
      step    <= 1'b0;
      paused  <= 1'b0;
      restart <= 1'b0;
      count   <= '0;
      wp      <= '0;
      rp      <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      hist    <= s2;
      restart <= rst_game;
      step    <= tick & ~rst_game;
      if (rst_game) begin
        dir    <= 2'd3;
        paused <= 1'b0;
        count  <= '0;
        wp     <= '0;
        rp     <= '0;
      end else begin
        if (press[4]) paused <= ~paused;
        if (pop) begin
          dir <= q[rp];
          rp  <= rp + AW'(1);
        end
        if (push) wp <= wp + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clock)
    if (push) q[wp] <= cand;
`ifdef SNAKE_DIR_BOOST_EN
  logic boost;
  // follows the held level of the button matching dir; drops with the edge that pauses or restarts
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) boost <= 1'b0;
    else boost <= ~rst_game & ~(paused ^ press[4]) & s2[dir];
  assign bus.boost = boost;
`else
  assign bus.boost = 1'b0;
`endif
  assign bus.dir     = dir;
  assign bus.step    = step;
  assign bus.paused  = paused;
  assign bus.restart = restart;
  assign bus.count   = count;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: table-driven check of snake_dir_ctrl (DEPTH=2, CW=2) plus boost and async-reset sequences
module tb_snake_dir_ctrl;
  localparam logic [5:0] UP = 6'd1, DN = 6'd2, LT = 6'd4, RT = 6'd8, ST = 6'd16, SL = 6'd32;
`ifdef SNAKE_DIR_BOOST_EN
  localparam logic BOOST = 1'b1;
`else
  localparam logic BOOST = 1'b0;
`endif
  typedef struct {
    logic [5:0] btn;
    logic       tick;
    logic [1:0] dir;
    logic       step, paused, restart;
    logic [1:0] cnt;
  } vec_t;
  logic clock = 1'b0, reset_n = 1'b0;
  int   errors = 0, checks = 0;
  vec_t vq[$];
  snake_dir_ctrl_if #(.CW(2)) bus ();
  snake_dir_ctrl #(.DEPTH(2), .CW(2)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic [5:0] b, input logic t, input logic [1:0] d,
                     input logic s, input logic p, input logic r, input logic [1:0] c);
    vec_t v;
    v = '{btn: b, tick: t, dir: d, step: s, paused: p, restart: r, cnt: c};
    vq.push_back(v);
  endtask
  task automatic drive(input logic [5:0] b, input logic t);
    {bus.sel, bus.start, bus.right, bus.left, bus.down, bus.up} = b;
    bus.game_tick = t;
  endtask
  task automatic cyc;
    @(posedge clock);
    #1;
  endtask
  initial begin
    drive(6'd0, 1'b0);
    cyc();
    cyc();
    chk("rst.dir", 8'(bus.dir), 8'd3);
    chk("rst.step", 8'(bus.step), 8'd0);
    chk("rst.paused", 8'(bus.paused), 8'd0);
    chk("rst.restart", 8'(bus.restart), 8'd0);
    chk("rst.count", 8'(bus.count), 8'd0);
    chk("rst.boost", 8'(bus.boost), 8'd0);
    reset_n = 1'b1;
    add(0, 0, 3, 0, 0, 0, 0);
    add(0, 1, 3, 1, 0, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0);
    add(UP, 0, 3, 0, 0, 0, 0); add(0, 0, 3, 0, 0, 0, 0); add(0, 0, 3, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(DN, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(UP, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(LT, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 1);
    add(RT, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1);
    add(UP | DN, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 2);
    add(RT, 0, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 0, 0, 2); add(0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 2, 1, 0, 0, 1); add(0, 1, 0, 1, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(LT, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0); add(0, 1, 0, 1, 0, 0, 1);
    add(DN, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1); add(0, 1, 2, 1, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 0);
    add(ST, 0, 1, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 0); add(0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0);
    add(LT, 0, 1, 0, 1, 0, 0); add(0, 0, 1, 0, 1, 0, 0); add(0, 0, 1, 0, 1, 0, 0);
    add(ST, 0, 1, 0, 1, 0, 0); add(0, 0, 1, 0, 1, 0, 0); add(0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0);
    add(RT, 0, 1, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 1);
    add(ST, 0, 1, 0, 0, 0, 1); add(0, 0, 1, 0, 0, 0, 1); add(0, 0, 1, 0, 1, 0, 1);
    add(0, 1, 1, 0, 1, 0, 1);
    add(SL | ST, 0, 1, 0, 1, 0, 1); add(0, 0, 1, 0, 1, 0, 1); add(0, 1, 3, 0, 0, 1, 0);
    add(0, 0, 3, 0, 0, 0, 0);
    add(SL, 0, 3, 0, 0, 0, 0); add(0, 0, 3, 0, 0, 0, 0); add(0, 0, 3, 0, 0, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i].btn, vq[i].tick);
      cyc();
      chk($sformatf("vec%0d.dir", i), 8'(bus.dir), 8'(vq[i].dir));
      chk($sformatf("vec%0d.step", i), 8'(bus.step), 8'(vq[i].step));
      chk($sformatf("vec%0d.paused", i), 8'(bus.paused), 8'(vq[i].paused));
      chk($sformatf("vec%0d.restart", i), 8'(bus.restart), 8'(vq[i].restart));
      chk($sformatf("vec%0d.count", i), 8'(bus.count), 8'(vq[i].cnt));
`ifndef SNAKE_DIR_BOOST_EN
      chk($sformatf("vec%0d.boost", i), 8'(bus.boost), 8'd0);
`endif
    end
    drive(RT, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("boost.hold%0d", i), 8'(bus.boost), 8'(BOOST & (i >= 3)));
    end
    chk("boost.redundant_cnt", 8'(bus.count), 8'd0);
    drive(6'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("boost.release%0d", i), 8'(bus.boost), 8'(BOOST & (i < 3)));
    end
    drive(UP, 1'b0);
    cyc(); cyc(); cyc();
    chk("ares.pre_count", 8'(bus.count), 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ares.count", 8'(bus.count), 8'd0);
    chk("ares.dir", 8'(bus.dir), 8'd3);
    chk("ares.paused", 8'(bus.paused), 8'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ares.edge1", 8'(bus.count), 8'd0);
    cyc();
    chk("ares.edge2", 8'(bus.count), 8'd0);
    cyc();
    chk("ares.edge3", 8'(bus.count), 8'd1);
    drive(UP, 1'b1);
    cyc();
    chk("ares.pop_dir", 8'(bus.dir), 8'd0);
    chk("ares.pop_step", 8'(bus.step), 8'd1);
    drive(UP, 1'b0);
    cyc();
    cyc();
    chk("ares.held_once", 8'(bus.count), 8'd0);
    chk("ares.step_low", 8'(bus.step), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
